payload_checker: RTL and testbench

Downstream stage of the frame header parser. After the header stage signals a complete, matching header, this block consumes the rest of the frame from the same `data`/`control` byte stream. The rest of the frame is the payload plus a 2-byte trailer checksum. The block counts payload bytes, checks the length against limits, verifies an additive 16-bit checksum, and keeps a wrapping count of good frames. Results are reported as one-cycle pulses when the frame ends.

---
 rtl/payload_checker.sv | 107 ++++++++++
 tb/tb_payload_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/payload_checker.sv
`default_nettype none
// payload_checker: counts payload bytes after a matched header, checks length
// limits and the additive 16-bit trailer checksum, and counts good frames.
// Revision: 1.0
module payload_checker #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        control,
  input  logic        hdr_done,
  output logic        packet_size_valid,
  output logic        checksum_valid,
  output logic        frame_error,
  output logic [10:0] payload_length,
  output logic [3:0]  good_frame_counter
);

  localparam logic [10:0] c_min_len = 11'(MIN_PAYLOAD);
  localparam logic [10:0] c_max_len = 11'(MAX_PAYLOAD);
  localparam logic [10:0] c_n_sat   = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [10:0] r_n;
  logic [15:0] r_sum;
  logic [7:0]  r_t1;
  logic [7:0]  r_t0;

  logic        w_n_ge2;
  logic        w_n_sat;
  logic [10:0] w_len;
  logic        w_size_ok;
  logic        w_sum_ok;

  // N, S and the trailer are frozen during REPORT, so the checks are evaluated there.
  always_comb begin
    w_n_ge2   = (r_n >= 11'd2);
    w_n_sat   = (r_n == c_n_sat);
    w_len     = w_n_ge2 ? (r_n - 11'd2) : 11'd0;
    w_size_ok = w_n_ge2 && !w_n_sat && (w_len >= c_min_len) && (w_len <= c_max_len);
    w_sum_ok  = w_n_ge2 && (r_sum == {r_t1, r_t0});
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state            <= IDLE;
      r_n                <= 11'd0;
      r_sum              <= 16'd0;
      r_t1               <= 8'd0;
      r_t0               <= 8'd0;
      packet_size_valid  <= 1'b0;
      checksum_valid     <= 1'b0;
      frame_error        <= 1'b0;
      payload_length     <= 11'd0;
      good_frame_counter <= 4'd0;
    end else begin
      packet_size_valid <= 1'b0;
      checksum_valid    <= 1'b0;
      frame_error       <= 1'b0;
      // Pulses are high in the cycle after REPORT; count on the following edge.
      if (packet_size_valid && checksum_valid)
        good_frame_counter <= good_frame_counter + 4'd1;

      case (r_state)
        IDLE: begin
          if (hdr_done && control) begin
            r_state <= PAYLOAD;
            r_n     <= 11'd0;
            r_sum   <= 16'd0;
            r_t1    <= 8'd0;
            r_t0    <= 8'd0;
          end
        end
        PAYLOAD: begin
          if (control) begin
            if (!w_n_sat)
              r_n <= r_n + 11'd1;
            r_t1 <= r_t0;
            r_t0 <= data;
            if (w_n_ge2)
              r_sum <= r_sum + {8'd0, r_t1};
          end else begin
            r_state <= REPORT;
          end
        end
        REPORT: begin
          packet_size_valid <= w_size_ok;
          checksum_valid    <= w_sum_ok;
          frame_error       <= !(w_size_ok && w_sum_ok);
          payload_length    <= w_n_sat ? c_n_sat : w_len;
          r_state           <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_payload_checker.sv
`default_nettype none
// Directed testbench for payload_checker: one task per scenario, inline checks.
// Revision: 1.0
module tb_payload_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        control = 1'b0;
  logic        hdr_done = 1'b0;
  logic        packet_size_valid;
  logic        checksum_valid;
  logic        frame_error;
  logic [10:0] payload_length;
  logic [3:0]  good_frame_counter;

  int vectors = 0;
  int miscompares = 0;

  payload_checker #(.MIN_PAYLOAD(46), .MAX_PAYLOAD(1500)) dut (
    .clock              (clock),
    .reset              (reset),
    .data               (data),
    .control            (control),
    .hdr_done           (hdr_done),
    .packet_size_valid  (packet_size_valid),
    .checksum_valid     (checksum_valid),
    .frame_error        (frame_error),
    .payload_length     (payload_length),
    .good_frame_counter (good_frame_counter)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sends header pulse, n payload bytes, trailer, then drops control.
  // Samples pulses and length after E+1, counter after E+2; stray flags
  // any pulse seen after E or after E+2.
  task automatic send_frame(input int n, input logic [7:0] fill,
                            input logic [7:0] t1, input logic [7:0] t0,
                            output logic psv, output logic csv, output logic fe,
                            output logic [10:0] plen, output logic [3:0] cnt,
                            output logic stray);
    hdr_done = 1'b1; control = 1'b1; data = 8'hA5; tick();
    hdr_done = 1'b0;
    for (int i = 0; i < n; i++) begin data = fill; tick(); end
    data = t1; tick();
    data = t0; tick();
    control = 1'b0; data = 8'd0; tick();
    stray = packet_size_valid | checksum_valid | frame_error;
    tick();
    psv = packet_size_valid; csv = checksum_valid; fe = frame_error;
    plen = payload_length;
    tick();
    cnt = good_frame_counter;
    stray = stray | packet_size_valid | checksum_valid | frame_error;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick();
    reset = 1'b1;
    vectors++;
    if ({packet_size_valid, checksum_valid, frame_error} !== 3'b000) begin
      miscompares++; $display("FAIL reset_pulses got %b want 000", {packet_size_valid, checksum_valid, frame_error});
    end
    vectors++;
    if (payload_length !== 11'd0) begin
      miscompares++; $display("FAIL reset_len got %0d want 0", payload_length);
    end
    vectors++;
    if (good_frame_counter !== 4'd0) begin
      miscompares++; $display("FAIL reset_cnt got %0d want 0", good_frame_counter);
    end
  endtask

  task automatic test_good_min();
    logic psv, csv, fe, st; logic [10:0] pl; logic [3:0] c;
    send_frame(46, 8'h01, 8'h00, 8'h2E, psv, csv, fe, pl, c, st);
    vectors++;
    if ({psv, csv, fe} !== 3'b110) begin
      miscompares++; $display("FAIL good_min_flags got %b want 110", {psv, csv, fe});
    end
    vectors++;
    if (pl !== 11'd46) begin miscompares++; $display("FAIL good_min_len got %0d want 46", pl); end
    vectors++;
    if (c !== 4'd1) begin miscompares++; $display("FAIL good_min_cnt got %0d want 1", c); end
    vectors++;
    if (st !== 1'b0) begin miscompares++; $display("FAIL good_min_latency stray pulse got %b want 0", st); end
  endtask

  task automatic test_bad_checksum();
    logic psv, csv, fe, st; logic [10:0] pl; logic [3:0] c;
    send_frame(46, 8'h01, 8'h00, 8'h2F, psv, csv, fe, pl, c, st);
    vectors++;
    if ({psv, csv, fe} !== 3'b101) begin
      miscompares++; $display("FAIL bad_cs_flags got %b want 101", {psv, csv, fe});
    end
    vectors++;
    if (pl !== 11'd46) begin miscompares++; $display("FAIL bad_cs_len got %0d want 46", pl); end
    vectors++;
    if (c !== 4'd1) begin miscompares++; $display("FAIL bad_cs_cnt got %0d want 1", c); end
  endtask

  task automatic test_length_bounds();
    logic psv, csv, fe, st; logic [10:0] pl; logic [3:0] c;
    send_frame(45, 8'h01, 8'h00, 8'h2D, psv, csv, fe, pl, c, st);
    vectors++;
    if ({psv, csv, fe} !== 3'b011) begin
      miscompares++; $display("FAIL len45_flags got %b want 011", {psv, csv, fe});
    end
    vectors++;
    if (pl !== 11'd45) begin miscompares++; $display("FAIL len45_len got %0d want 45", pl); end
    // 1500 * 0xFF = 382500 -> mod 2^16 = 0xD624
    send_frame(1500, 8'hFF, 8'hD6, 8'h24, psv, csv, fe, pl, c, st);
    vectors++;
    if ({psv, csv, fe} !== 3'b110) begin
      miscompares++; $display("FAIL len1500_flags got %b want 110", {psv, csv, fe});
    end
    vectors++;
    if (pl !== 11'd1500) begin miscompares++; $display("FAIL len1500_len got %0d want 1500", pl); end
    vectors++;
    if (c !== 4'd2) begin miscompares++; $display("FAIL len1500_cnt got %0d want 2", c); end
    // 1501 * 0xFF = 382755 -> 0xD723
    send_frame(1501, 8'hFF, 8'hD7, 8'h23, psv, csv, fe, pl, c, st);
    vectors++;
    if ({psv, csv, fe} !== 3'b011) begin
      miscompares++; $display("FAIL len1501_flags got %b want 011", {psv, csv, fe});
    end
    vectors++;
    if (pl !== 11'd1501) begin miscompares++; $display("FAIL len1501_len got %0d want 1501", pl); end
    send_frame(2100, 8'hFF, 8'h00, 8'h00, psv, csv, fe, pl, c, st);
    vectors++;
    if (pl !== 11'd2047) begin miscompares++; $display("FAIL len2100_len got %0d want 2047", pl); end
    vectors++;
    if ({psv, fe} !== 2'b01) begin
      miscompares++; $display("FAIL len2100_flags psv,fe got %b want 01", {psv, fe});
    end
    vectors++;
    if (c !== 4'd2) begin miscompares++; $display("FAIL len2100_cnt got %0d want 2", c); end
  endtask

  task automatic test_reset_midframe();
    logic psv, csv, fe, st, seen; logic [10:0] pl; logic [3:0] c;
    hdr_done = 1'b1; control = 1'b1; data = 8'hA5; tick();
    hdr_done = 1'b0;
    for (int i = 0; i < 20; i++) begin data = 8'h01; tick(); end
    reset = 1'b0; tick();
    reset = 1'b1; control = 1'b0; data = 8'd0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | packet_size_valid | checksum_valid | frame_error;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL midreset_pulse got %b want 0", seen); end
    vectors++;
    if (payload_length !== 11'd0) begin
      miscompares++; $display("FAIL midreset_len got %0d want 0", payload_length);
    end
    vectors++;
    if (good_frame_counter !== 4'd0) begin
      miscompares++; $display("FAIL midreset_cnt got %0d want 0", good_frame_counter);
    end
    send_frame(46, 8'h01, 8'h00, 8'h2E, psv, csv, fe, pl, c, st);
    vectors++;
    if ({psv, csv, fe} !== 3'b110) begin
      miscompares++; $display("FAIL midreset_follow_flags got %b want 110", {psv, csv, fe});
    end
    vectors++;
    if (c !== 4'd1) begin miscompares++; $display("FAIL midreset_follow_cnt got %0d want 1", c); end
  endtask

  task automatic test_short();
    hdr_done = 1'b1; control = 1'b1; data = 8'hA5; tick();
    hdr_done = 1'b0; data = 8'hAA; tick();
    control = 1'b0; data = 8'd0; tick();
    tick();
    vectors++;
    if ({packet_size_valid, checksum_valid, frame_error} !== 3'b001) begin
      miscompares++; $display("FAIL short_flags got %b want 001", {packet_size_valid, checksum_valid, frame_error});
    end
    vectors++;
    if (payload_length !== 11'd0) begin
      miscompares++; $display("FAIL short_len got %0d want 0", payload_length);
    end
    tick();
    vectors++;
    if (good_frame_counter !== 4'd1) begin
      miscompares++; $display("FAIL short_cnt got %0d want 1", good_frame_counter);
    end
  endtask

  task automatic test_counter_wrap();
    logic psv, csv, fe, st; logic [10:0] pl; logic [3:0] c; logic [3:0] exp_c;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    for (int k = 1; k <= 17; k++) begin
      send_frame(46, 8'h01, 8'h00, 8'h2E, psv, csv, fe, pl, c, st);
      exp_c = 4'(k % 16);
      vectors++;
      if (c !== exp_c) begin
        miscompares++; $display("FAIL wrap_cnt frame %0d got %0d want %0d", k, c, exp_c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_min();
    test_bad_checksum();
    test_length_bounds();
    test_reset_midframe();
    test_short();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
